native_read_arbiter: RTL and testbench

- Shares one native-bus read channel (raddr/rdata valid/ready pair) between two requesters, typically the instruction fetch (port 0) and the data load unit (port 1).
- Sits between the core's bus masters and a single native memory slave, e.g. a unified instruction+data memory.
- Allows one outstanding read at a time. Selects a winner by round-robin or fixed priority and routes the response back to the owner.
- A response watchdog converts a hung slave into an error response.

---
 rtl/native_read_arbiter_pkg.sv | 20 ++
 rtl/arb_grant2.sv | 28 ++
 rtl/native_read_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_native_read_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/native_read_arbiter_pkg.sv
// Shared types and constants for the two-port native read arbiter.
package native_read_arbiter_pkg;

    localparam int BUS_WIDTH = 32;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_DATA = 2'd2,
        ARB_ERR  = 2'd3
    } arb_state_e;

    localparam logic ARB_RR    = 1'b0;
    localparam logic ARB_FIXED = 1'b1;

    function automatic logic [1:0] port_onehot(input logic port);
        return port ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/arb_grant2.sv
// Combinational two-way grant: round-robin against last_grant, or fixed with port 0 first.
module arb_grant2
    import native_read_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    input  logic       mode_i,
    output logic [1:0] gnt_o
);

    // one-hot winner; ties go to port 0 in fixed mode, otherwise to the port not served last
    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11: begin
                if (mode_i == ARB_FIXED) begin
                    gnt_o = 2'b01;
                end else begin
                    gnt_o = port_onehot(~last_grant_i);
                end
            end
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/native_read_arbiter.sv
// Shares one native read channel between two masters, one read outstanding at a time,
// with a response watchdog that turns a hung slave into an error response.
module native_read_arbiter
    import native_read_arbiter_pkg::*;
#(
    parameter int                   PRIORITY_MODE  = 0,
    parameter int                   TIMEOUT_CYCLES = 256,
    parameter logic [BUS_WIDTH-1:0] ERR_DATA       = 32'hDEAD_BEEF
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 m0_raddr_valid,
    input  logic [BUS_WIDTH-1:0] m0_raddr,
    output logic                 m0_raddr_ready,
    output logic                 m0_rdata_valid,
    output logic [BUS_WIDTH-1:0] m0_rdata,
    input  logic                 m0_rdata_ready,

    input  logic                 m1_raddr_valid,
    input  logic [BUS_WIDTH-1:0] m1_raddr,
    output logic                 m1_raddr_ready,
    output logic                 m1_rdata_valid,
    output logic [BUS_WIDTH-1:0] m1_rdata,
    input  logic                 m1_rdata_ready,

    output logic                 s_raddr_valid,
    output logic [BUS_WIDTH-1:0] s_raddr,
    input  logic                 s_raddr_ready,
    input  logic                 s_rdata_valid,
    input  logic [BUS_WIDTH-1:0] s_rdata,
    output logic                 s_rdata_ready,

    output logic                 timeout_err
);

    localparam int              WDOG_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic            WDOG_EN   = (TIMEOUT_CYCLES > 0);
    localparam logic [WDOG_W-1:0] WDOG_LAST = (TIMEOUT_CYCLES > 0) ? WDOG_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic            MODE      = (PRIORITY_MODE != 0) ? ARB_FIXED : ARB_RR;

    arb_state_e           state_q, state_d;
    logic                 owner_q, owner_d;
    logic                 last_grant_q, last_grant_d;
    logic [BUS_WIDTH-1:0] s_raddr_q, s_raddr_d;
    logic [WDOG_W-1:0]    wdog_q, wdog_d;
    logic                 timeout_err_q, timeout_err_d;

    logic [1:0]           req_s;
    logic [1:0]           gnt_s;
    logic                 owner_rdata_ready_s;
    logic                 wdog_fire_s;

    assign req_s = {m1_raddr_valid, m0_raddr_valid};

    arb_grant2 u_grant (
        .req_i        (req_s),
        .last_grant_i (last_grant_q),
        .mode_i       (MODE),
        .gnt_o        (gnt_s)
    );

    assign owner_rdata_ready_s = owner_q ? m1_rdata_ready : m0_rdata_ready;
    assign wdog_fire_s         = WDOG_EN && (wdog_q == WDOG_LAST) && !s_rdata_valid;

    // next-state, owner/address capture and watchdog counting
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_grant_d  = last_grant_q;
        s_raddr_d     = s_raddr_q;
        wdog_d        = wdog_q;
        timeout_err_d = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (gnt_s != 2'b00) begin
                    owner_d      = gnt_s[1];
                    last_grant_d = gnt_s[1];
                    s_raddr_d    = gnt_s[1] ? m1_raddr : m0_raddr;
                    state_d      = ARB_ADDR;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_ADDR: begin
                if (s_raddr_ready) begin
                    wdog_d  = '0;
                    state_d = ARB_DATA;
                end else begin
                    state_d = ARB_ADDR;
                end
            end
            ARB_DATA: begin
                if (s_rdata_valid) begin
                    if (owner_rdata_ready_s) begin
                        state_d = ARB_IDLE;
                    end else begin
                        state_d = ARB_DATA;
                    end
                end else if (wdog_fire_s) begin
                    timeout_err_d = 1'b1;
                    state_d       = ARB_ERR;
                end else begin
                    wdog_d = wdog_q + WDOG_W'(1);
                end
            end
            ARB_ERR: begin
                if (owner_rdata_ready_s) begin
                    state_d = ARB_IDLE;
                end else begin
                    state_d = ARB_ERR;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // state and datapath registers; last_grant resets to 1 so port 0 wins the first tie
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ARB_IDLE;
            owner_q       <= 1'b0;
            last_grant_q  <= 1'b1;
            s_raddr_q     <= '0;
            wdog_q        <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_grant_q  <= last_grant_d;
            s_raddr_q     <= s_raddr_d;
            wdog_q        <= wdog_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // output decode; everything is held low while rst is asserted, including IDLE's drain ready
    always_comb begin
        m0_raddr_ready = 1'b0;
        m1_raddr_ready = 1'b0;
        m0_rdata_valid = 1'b0;
        m1_rdata_valid = 1'b0;
        m0_rdata       = '0;
        m1_rdata       = '0;
        s_raddr_valid  = 1'b0;
        s_rdata_ready  = 1'b0;
        if (!rst) begin
            case (state_q)
                ARB_IDLE: begin
                    m0_raddr_ready = gnt_s[0];
                    m1_raddr_ready = gnt_s[1];
                    s_rdata_ready  = 1'b1;
                end
                ARB_ADDR: begin
                    s_raddr_valid = 1'b1;
                end
                ARB_DATA: begin
                    s_rdata_ready = owner_rdata_ready_s;
                    if (owner_q) begin
                        m1_rdata_valid = s_rdata_valid;
                        m1_rdata       = s_rdata;
                    end else begin
                        m0_rdata_valid = s_rdata_valid;
                        m0_rdata       = s_rdata;
                    end
                end
                ARB_ERR: begin
                    s_rdata_ready = 1'b1;
                    if (owner_q) begin
                        m1_rdata_valid = 1'b1;
                        m1_rdata       = ERR_DATA;
                    end else begin
                        m0_rdata_valid = 1'b1;
                        m0_rdata       = ERR_DATA;
                    end
                end
                default: begin
                    s_rdata_ready = 1'b0;
                end
            endcase
        end else begin
            s_rdata_ready = 1'b0;
        end
    end

    assign s_raddr     = s_raddr_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_native_read_arbiter.sv
// Scoreboard bench: instance 0 is round-robin, instance 1 fixed priority, both with an 8-cycle watchdog.
module tb_native_read_arbiter;

    typedef struct {
        int          port;
        logic [31:0] data;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        av [2][2];
    logic [31:0] ad [2][2];
    logic        ar [2][2];
    logic        rv [2][2];
    logic [31:0] rd [2][2];
    logic        rr [2][2];

    logic        sav [2];
    logic [31:0] sad [2];
    logic        sar [2];
    logic        srr [2];
    logic        terr [2];

    logic        pend [2];
    logic        hang [2];
    logic        slv_v [2];
    logic [31:0] slv_a [2];
    logic [31:0] slv_d [2];

    int   gnt_q [2][$];
    rsp_t rsp_q [2][$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        native_read_arbiter #(
            .PRIORITY_MODE  (k),
            .TIMEOUT_CYCLES (8),
            .ERR_DATA       (32'hDEAD_BEEF)
        ) u_dut (
            .clk            (clk),
            .rst            (rst),
            .m0_raddr_valid (av[k][0]),
            .m0_raddr       (ad[k][0]),
            .m0_raddr_ready (ar[k][0]),
            .m0_rdata_valid (rv[k][0]),
            .m0_rdata       (rd[k][0]),
            .m0_rdata_ready (rr[k][0]),
            .m1_raddr_valid (av[k][1]),
            .m1_raddr       (ad[k][1]),
            .m1_raddr_ready (ar[k][1]),
            .m1_rdata_valid (rv[k][1]),
            .m1_rdata       (rd[k][1]),
            .m1_rdata_ready (rr[k][1]),
            .s_raddr_valid  (sav[k]),
            .s_raddr        (sad[k]),
            .s_raddr_ready  (sar[k]),
            .s_rdata_valid  (slv_v[k]),
            .s_rdata        (slv_d[k]),
            .s_rdata_ready  (srr[k]),
            .timeout_err    (terr[k])
        );
    end

    function automatic logic [31:0] mem(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'hA0A0_0000;
            32'h0000_0004: return 32'hB1B1_0004;
            32'h0000_0010: return 32'h1122_3344;
            default:       return a ^ 32'h5A5A_0000;
        endcase
    endfunction

    // slave model: accepts an address, returns data one cycle later unless hung
    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                pend[k]  <= 1'b0;
                slv_v[k] <= 1'b0;
                slv_a[k] <= 32'h0;
                slv_d[k] <= 32'h0;
            end else begin
                if (sav[k] && sar[k]) begin
                    pend[k]  <= 1'b1;
                    slv_a[k] <= sad[k];
                end else if (pend[k] && !hang[k] && !slv_v[k]) begin
                    pend[k]  <= 1'b0;
                    slv_v[k] <= 1'b1;
                    slv_d[k] <= mem(slv_a[k]);
                end
                if (slv_v[k] && srr[k]) slv_v[k] <= 1'b0;
            end
        end
    end

    // monitor: every grant and every master response handshake is checked against the queues
    always @(negedge clk) begin
        int   g;
        rsp_t e;
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                for (int p = 0; p < 2; p++) begin
                    if (av[k][p] && ar[k][p]) begin
                        total++;
                        if (gnt_q[k].size() == 0) begin
                            bad++;
                            $display("FAIL grant[%0d]: got port %0d, required no grant", k, p);
                        end else begin
                            g = gnt_q[k].pop_front();
                            if (g != p) begin
                                bad++;
                                $display("FAIL grant[%0d]: got port %0d, required port %0d", k, p, g);
                            end
                        end
                    end
                    if (rv[k][p] && rr[k][p]) begin
                        total++;
                        if (rsp_q[k].size() == 0) begin
                            bad++;
                            $display("FAIL rsp[%0d]: got port %0d data %h, required no response", k, p, rd[k][p]);
                        end else begin
                            e = rsp_q[k].pop_front();
                            if (e.port != p || rd[k][p] !== e.data) begin
                                bad++;
                                $display("FAIL rsp[%0d]: got port %0d data %h, required port %0d data %h",
                                         k, p, rd[k][p], e.port, e.data);
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_rsp(input int k, input int p, input logic [31:0] d);
        rsp_t e;
        e.port = p;
        e.data = d;
        gnt_q[k].push_back(p);
        rsp_q[k].push_back(e);
    endtask

    // holds valid until the handshake edge, then drops it
    task automatic wait_hs(input int k, input int p, input int budget);
        bit hit = 1'b0;
        for (int c = 0; c < budget && !hit; c++) begin
            @(negedge clk);
            hit = av[k][p] && ar[k][p];
            tick();
        end
        chk("handshake_seen", 32'(hit), 32'd1);
        av[k][p] = 1'b0;
    endtask

    task automatic contend(input int k, input int n0, input int n1);
        int need [2];
        bit hs [2];
        need[0] = n0;
        need[1] = n1;
        ad[k][0] = 32'h0;
        ad[k][1] = 32'h4;
        av[k][0] = (n0 > 0);
        av[k][1] = (n1 > 0);
        for (int c = 0; c < 100 && (need[0] + need[1]) > 0; c++) begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) hs[p] = av[k][p] && ar[k][p];
            tick();
            for (int p = 0; p < 2; p++) begin
                if (hs[p]) begin
                    need[p]--;
                    if (need[p] == 0) av[k][p] = 1'b0;
                end
            end
        end
        chk("contend_done", 32'(need[0] + need[1]), 32'd0);
    endtask

    task automatic wait_drain(input int k, input int budget);
        for (int c = 0; c < budget && rsp_q[k].size() != 0; c++) tick();
        chk("drain", 32'(rsp_q[k].size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish, required finish before 100us");
        $fatal(1, "bench timeout");
    end

    initial begin
        bit seen;
        for (int k = 0; k < 2; k++) begin
            sar[k]  = 1'b1;
            hang[k] = 1'b0;
            for (int p = 0; p < 2; p++) begin
                av[k][p] = 1'b1;
                ad[k][p] = 32'h0;
                rr[k][p] = 1'b1;
            end
        end

        // reset: outputs low even with requests pending
        #2;
        chk("rst_m0_ready", 32'(ar[0][0]), 32'd0);
        chk("rst_m1_ready", 32'(ar[0][1]), 32'd0);
        chk("rst_s_rready", 32'(srr[0]), 32'd0);
        chk("rst_s_avalid", 32'(sav[0]), 32'd0);
        chk("rst_s_raddr", sad[0], 32'h0);
        chk("rst_terr", 32'(terr[0]), 32'd0);
        for (int k = 0; k < 2; k++) for (int p = 0; p < 2; p++) av[k][p] = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // round-robin contention
        for (int i = 0; i < 3; i++) begin
            exp_rsp(0, 0, 32'hA0A0_0000);
            exp_rsp(0, 1, 32'hB1B1_0004);
        end
        contend(0, 3, 3);
        wait_drain(0, 20);

        // single port latency
        exp_rsp(0, 0, 32'h1122_3344);
        av[0][0] = 1'b1;
        ad[0][0] = 32'h10;
        @(negedge clk);
        chk("sp_c0_m0_ready", 32'(ar[0][0]), 32'd1);
        chk("sp_c0_m1_ready", 32'(ar[0][1]), 32'd0);
        tick();
        av[0][0] = 1'b0;
        @(negedge clk);
        chk("sp_c1_s_avalid", 32'(sav[0]), 32'd1);
        chk("sp_c1_s_raddr", sad[0], 32'h10);
        tick();
        @(negedge clk);
        chk("sp_c2_m0_rvalid", 32'(rv[0][0]), 32'd0);
        tick();
        @(negedge clk);
        chk("sp_c3_m0_rvalid", 32'(rv[0][0]), 32'd1);
        chk("sp_c3_m0_rdata", rd[0][0], 32'h1122_3344);
        chk("sp_c3_m1_rvalid", 32'(rv[0][1]), 32'd0);
        tick();
        wait_drain(0, 10);

        // backpressure on m1 while m0 waits
        exp_rsp(0, 1, 32'h5A5A_0020);
        exp_rsp(0, 0, 32'hA0A0_0000);
        rr[0][1] = 1'b0;
        av[0][1] = 1'b1;
        ad[0][1] = 32'h20;
        wait_hs(0, 1, 10);
        av[0][0] = 1'b1;
        ad[0][0] = 32'h0;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            seen = rv[0][1];
            if (!seen) tick();
        end
        chk("bp_valid_seen", 32'(seen), 32'd1);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk("bp_m1_rvalid", 32'(rv[0][1]), 32'd1);
            chk("bp_m1_rdata", rd[0][1], 32'h5A5A_0020);
            chk("bp_s_rready", 32'(srr[0]), 32'd0);
            chk("bp_m0_ready", 32'(ar[0][0]), 32'd0);
            tick();
        end
        rr[0][1] = 1'b1;
        wait_hs(0, 0, 10);
        wait_drain(0, 10);

        // watchdog timeout with a late slave response during ERR
        exp_rsp(0, 0, 32'hDEAD_BEEF);
        hang[0]  = 1'b1;
        rr[0][0] = 1'b0;
        av[0][0] = 1'b1;
        ad[0][0] = 32'h30;
        wait_hs(0, 0, 10);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            chk("to_terr", 32'(terr[0]), 32'(c == 10));
            chk("to_m0_rvalid", 32'(rv[0][0]), 32'(c >= 10));
            if (c >= 10) chk("to_m0_rdata", rd[0][0], 32'hDEAD_BEEF);
            if (c == 12) begin
                chk("to_late_svalid", 32'(slv_v[0]), 32'd1);
                chk("to_late_drain", 32'(srr[0]), 32'd1);
            end
            tick();
            if (c == 10) hang[0] = 1'b0;
        end
        rr[0][0] = 1'b1;
        wait_drain(0, 10);
        tick();
        tick();

        // fixed priority on instance 1
        for (int i = 0; i < 4; i++) exp_rsp(1, 0, 32'hA0A0_0000);
        exp_rsp(1, 1, 32'hB1B1_0004);
        contend(1, 4, 1);
        wait_drain(1, 30);

        // async reset in DATA
        gnt_q[0].push_back(0);
        av[0][0] = 1'b1;
        ad[0][0] = 32'h10;
        wait_hs(0, 0, 10);
        tick();
        #3;
        rst = 1'b1;
        #1;
        chk("ar_s_avalid", 32'(sav[0]), 32'd0);
        chk("ar_s_rready", 32'(srr[0]), 32'd0);
        chk("ar_s_raddr", sad[0], 32'h0);
        chk("ar_m0_rvalid", 32'(rv[0][0]), 32'd0);
        chk("ar_m0_rdata", rd[0][0], 32'h0);
        chk("ar_terr", 32'(terr[0]), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        exp_rsp(0, 0, 32'hA0A0_0000);
        exp_rsp(0, 1, 32'hB1B1_0004);
        contend(0, 1, 1);
        wait_drain(0, 20);

        chk("end_gnt_q0", 32'(gnt_q[0].size()), 32'd0);
        chk("end_gnt_q1", 32'(gnt_q[1].size()), 32'd0);
        chk("end_rsp_q1", 32'(rsp_q[1].size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
